// File: rtl/mdio_cfg_pkg.sv
// Shared types and constants for the MDIO PHY configuration sequencer.
package mdio_cfg_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_CFG_ISSUE,
    S_CFG_WAIT,
    S_POLL_DLY,
    S_RD_BMSR,
    S_WT_BMSR,
    S_RD_PSSR,
    S_WT_PSSR
  } state_t;

  localparam logic [4:0] REG_BMSR      = 5'd1;
  localparam logic [4:0] REG_PSSR      = 5'd17;
  localparam int         BMSR_LINK_BIT = 2;
  localparam int         PSSR_SPD_MSB  = 15;
  localparam int         CFG_W         = 21;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/mdio_cfg_rom.sv
// Fixed PHY register write table; unused slots read as zero.
module mdio_cfg_rom
  import mdio_cfg_pkg::*;
(
  input  logic [2:0]  idx,
  output cfg_entry_t  entry
);

  always_comb begin
    entry = '0;
    case (idx)
      3'd0:    entry = '{addr: 5'd0, data: 16'h9140};  // AN enable + soft reset
      3'd1:    entry = '{addr: 5'd4, data: 16'h01E1};
      3'd2:    entry = '{addr: 5'd9, data: 16'h0300};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/mdio_phy_cfg_seq.sv
// Drives the MDIO master command port: writes the PHY config table after reset,
// then polls BMSR/PSSR and publishes link state as an atomic pair.
module mdio_phy_cfg_seq
  import mdio_cfg_pkg::*;
#(
  parameter int PWRUP_DLY   = 200000,
  parameter int POLL_PERIOD = 500000,
  parameter int OP_TIMEOUT  = 4096,
  parameter int N_CFG       = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_restart,
  output logic        op_exec,
  output logic        op_rh_wl,
  output logic [4:0]  op_addr,
  output logic [15:0] op_wr_data,
  input  logic        op_done,
  input  logic [15:0] op_rd_data,
  input  logic        op_rd_ack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        link_up,
  output logic [1:0]  link_speed
);

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [31:0] cnt, cnt_nx;
  logic        rst_pend, rst_pend_nx;
  logic        shadow, shadow_nx;
  logic        cfg_done_nx, cfg_err_nx, link_up_nx;
  logic [1:0]  link_speed_nx;
  logic        take_restart, op_tmo;
  cfg_entry_t  ent;
  logic        unused_rd;

  assign unused_rd = ^{op_rd_data[13:3], op_rd_data[1:0]};

  mdio_cfg_rom u_rom (.idx(idx), .entry(ent));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_PWRUP;
      idx        <= '0;
      cnt        <= '0;
      rst_pend   <= 1'b0;
      shadow     <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      link_up    <= 1'b0;
      link_speed <= 2'b00;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      rst_pend   <= rst_pend_nx;
      shadow     <= shadow_nx;
      cfg_done   <= cfg_done_nx;
      cfg_err    <= cfg_err_nx;
      link_up    <= link_up_nx;
      link_speed <= link_speed_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    cnt_nx        = cnt + 32'd1;
    rst_pend_nx   = rst_pend | cfg_restart;
    shadow_nx     = shadow;
    cfg_done_nx   = cfg_done;
    cfg_err_nx    = cfg_err;
    link_up_nx    = link_up;
    link_speed_nx = link_speed;
    op_exec       = 1'b0;
    op_rh_wl      = 1'b0;
    op_addr       = '0;
    op_wr_data    = '0;
    busy          = 1'b0;
    take_restart  = 1'b0;
    // op_done on the last allowed cycle wins over the timeout
    op_tmo        = !op_done && (cnt == 32'(OP_TIMEOUT - 1));

    case (state)
      S_PWRUP: begin
        if (rst_pend) take_restart = 1'b1;
        else if (cnt == 32'(PWRUP_DLY - 1)) begin
          state_nx = S_CFG_ISSUE;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      S_CFG_ISSUE: begin
        op_exec    = 1'b1;
        op_addr    = ent.addr;
        op_wr_data = ent.data;
        cnt_nx     = '0;
        state_nx   = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        busy       = 1'b1;
        op_addr    = ent.addr;
        op_wr_data = ent.data;
        if (op_done) begin
          take_restart = rst_pend;
          cnt_nx       = '0;
          if (idx == 3'(N_CFG - 1)) begin
            cfg_done_nx = 1'b1;
            idx_nx      = '0;
            state_nx    = S_POLL_DLY;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = S_CFG_ISSUE;
          end
        end else if (op_tmo) begin
          take_restart = rst_pend;
          cfg_err_nx   = 1'b1;
          idx_nx       = '0;
          cnt_nx       = '0;
          state_nx     = S_POLL_DLY;
        end
      end
      S_POLL_DLY: begin
        if (rst_pend) take_restart = 1'b1;
        else if (cnt == 32'(POLL_PERIOD - 1)) begin
          cnt_nx   = '0;
          state_nx = S_RD_BMSR;
        end
      end
      S_RD_BMSR, S_RD_PSSR: begin
        op_exec  = 1'b1;
        op_rh_wl = 1'b1;
        op_addr  = (state == S_RD_BMSR) ? REG_BMSR : REG_PSSR;
        cnt_nx   = '0;
        state_nx = (state == S_RD_BMSR) ? S_WT_BMSR : S_WT_PSSR;
      end
      S_WT_BMSR, S_WT_PSSR: begin
        busy     = 1'b1;
        op_rh_wl = 1'b1;
        op_addr  = (state == S_WT_BMSR) ? REG_BMSR : REG_PSSR;
        if (op_done || op_tmo) begin
          take_restart = rst_pend;
          cnt_nx       = '0;
          state_nx     = S_POLL_DLY;
          if (op_tmo || op_rd_ack) cfg_err_nx = 1'b1;
          else if (state == S_WT_BMSR) begin
            shadow_nx = op_rd_data[BMSR_LINK_BIT];
            state_nx  = S_RD_PSSR;
          end else begin
            // link state only ever moves as a complete BMSR+PSSR pair
            link_up_nx    = shadow;
            link_speed_nx = op_rd_data[PSSR_SPD_MSB -: 2];
          end
        end
      end
      default: state_nx = S_PWRUP;
    endcase

    if (take_restart) begin
      state_nx    = S_CFG_ISSUE;
      idx_nx      = '0;
      cnt_nx      = '0;
      rst_pend_nx = 1'b0;
      cfg_done_nx = 1'b0;
      cfg_err_nx  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mdio_phy_cfg_seq.sv
// Directed bench: MDIO driver model answers each op_exec with op_done 64 cycles later.
module tb_mdio_phy_cfg_seq;

  localparam int PWRUP_DLY   = 100;
  localparam int POLL_PERIOD = 300;
  localparam int OP_TIMEOUT  = 200;
  localparam int N_CFG       = 3;
  localparam int MAXW        = 1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_restart = 1'b0;
  logic        op_exec, op_rh_wl, busy, cfg_done, cfg_err, link_up;
  logic [4:0]  op_addr;
  logic [15:0] op_wr_data;
  logic [1:0]  link_speed;
  logic        op_done = 1'b0;
  logic [15:0] op_rd_data = 16'h0;
  logic        op_rd_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  int n;

  // driver model knobs
  logic        hold_en = 1'b0;
  logic [4:0]  hold_addr = 5'd4;
  logic [15:0] bmsr_val = 16'h0000;
  logic [15:0] pssr_val = 16'h0000;
  logic        bmsr_nack = 1'b0;
  logic        mdl_pend = 1'b0;
  logic        mdl_rd = 1'b0;
  logic [4:0]  mdl_addr = 5'd0;
  int          mdl_cnt = 0;

  mdio_phy_cfg_seq #(
    .PWRUP_DLY(PWRUP_DLY), .POLL_PERIOD(POLL_PERIOD),
    .OP_TIMEOUT(OP_TIMEOUT), .N_CFG(N_CFG)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_restart(cfg_restart),
    .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_addr(op_addr), .op_wr_data(op_wr_data),
    .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .link_up(link_up), .link_speed(link_speed)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_exec(input string tag, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!op_exec && cyc < MAXW);
    chk({tag, "_seen"}, 32'(op_exec), 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (busy && cyc < MAXW);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_restart();
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
  endtask

  // MDIO driver model, evaluated mid-cycle on stable DUT outputs
  always @(negedge sys_clk) begin
    op_done   = 1'b0;
    op_rd_ack = 1'b0;
    if (sys_rst) mdl_pend = 1'b0;
    else begin
      if (mdl_pend) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mdl_pend = 1'b0;
          op_done  = 1'b1;
          if (mdl_rd) begin
            op_rd_data = (mdl_addr == 5'd1) ? bmsr_val : pssr_val;
            op_rd_ack  = (mdl_addr == 5'd1) && bmsr_nack;
          end
        end
      end
      if (op_exec) begin
        chk("exec_while_busy", 32'(busy), 32'd0);
        if (!(hold_en && !op_rh_wl && op_addr == hold_addr)) begin
          mdl_pend = 1'b1;
          mdl_cnt  = 64;
          mdl_rd   = op_rh_wl;
          mdl_addr = op_addr;
        end
      end
    end
  end

  initial begin
    // 1: reset state, power-up delay, config writes
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_exec", 32'(op_exec), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {cfg_done, cfg_err, link_up, link_speed, op_rh_wl}, 0);
    chk("rst_addr_data", {op_addr, op_wr_data}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_exec("pwrup", n);
    chk("pwrup_lat", n, PWRUP_DLY);  // op_exec lands in cycle PWRUP_DLY+1
    chk("w0_op", {op_rh_wl, op_addr, op_wr_data}, {1'b0, 5'd0, 16'h9140});
    tick();
    chk("w0_busy", 32'(busy), 1);
    chk("w0_exec_low", 32'(op_exec), 0);
    wait_exec("w1", n);
    chk("w1_gap", n, 64);
    chk("w1_op", {op_rh_wl, op_addr, op_wr_data}, {1'b0, 5'd4, 16'h01E1});
    wait_exec("w2", n);
    chk("w2_op", {op_rh_wl, op_addr, op_wr_data}, {1'b0, 5'd9, 16'h0300});
    chk("w2_cfg_done_early", 32'(cfg_done), 0);
    wait_idle("w2", n);
    chk("cfg_done", {cfg_done, cfg_err}, 2'b10);

    // 2: good poll pair publishes link
    bmsr_val = 16'h0004;
    pssr_val = 16'h8000;
    wait_exec("bmsr", n);
    chk("poll_period", n, POLL_PERIOD);
    chk("bmsr_op", {op_rh_wl, op_addr}, {1'b1, 5'd1});
    wait_exec("pssr", n);
    chk("pssr_op", {op_rh_wl, op_addr}, {1'b1, 5'd17});
    chk("link_before_pssr", {link_up, link_speed}, 3'b000);
    wait_idle("pssr", n);
    chk("link_after_pssr", {link_up, link_speed}, 3'b110);
    chk("cfg_done_kept", 32'(cfg_done), 1);

    // 3: write 2 never completes -> timeout
    hold_en = 1'b1;
    pulse_restart();
    wait_exec("rs_w0", n);
    chk("restart_lat", n, 1);
    chk("rs_w0_addr", 32'(op_addr), 0);
    chk("rs_cleared", {cfg_done, cfg_err}, 2'b00);
    chk("rs_link_kept", {link_up, link_speed}, 3'b110);
    wait_exec("rs_w1", n);
    chk("rs_w1_addr", 32'(op_addr), 4);
    n = 0;
    do begin tick(); n++; end while (!cfg_err && n < MAXW);
    chk("tmo_cycles", n, OP_TIMEOUT + 1);
    chk("tmo_state", {busy, cfg_done}, 2'b00);
    hold_en  = 1'b0;
    bmsr_val = 16'h0000;
    pssr_val = 16'h4000;
    wait_exec("tmo_bmsr", n);
    chk("tmo_poll_period", n, POLL_PERIOD);
    chk("tmo_bmsr_op", {op_rh_wl, op_addr}, {1'b1, 5'd1});
    wait_exec("tmo_pssr", n);
    wait_idle("tmo_pssr", n);
    chk("tmo_link", {link_up, link_speed}, 3'b001);
    chk("tmo_err_sticky", 32'(cfg_err), 1);

    // 4: BMSR nack -> error, no PSSR, link untouched
    pulse_restart();
    wait_exec("n_w0", n);
    wait_exec("n_w1", n);
    wait_exec("n_w2", n);
    wait_idle("n_w2", n);
    chk("n_cfg_ok", {cfg_done, cfg_err}, 2'b10);
    bmsr_nack = 1'b1;
    bmsr_val  = 16'h0004;
    wait_exec("n_bmsr", n);
    wait_idle("n_bmsr", n);
    chk("nack_err", 32'(cfg_err), 1);
    chk("nack_link", {link_up, link_speed}, 3'b001);
    bmsr_nack = 1'b0;
    pssr_val  = 16'h8000;
    wait_exec("n_next", n);
    chk("nack_no_pssr_gap", n, POLL_PERIOD);
    chk("nack_no_pssr_addr", 32'(op_addr), 1);
    wait_exec("n_pssr", n);
    wait_idle("n_pssr", n);
    chk("n_link", {link_up, link_speed}, 3'b110);

    // 5: two restarts during a busy write collapse to one rerun
    pulse_restart();
    wait_exec("d_w0", n);
    chk("d_err_cleared", 32'(cfg_err), 0);
    repeat (5) tick();
    pulse_restart();
    repeat (5) tick();
    pulse_restart();
    wait_exec("d_rerun", n);
    chk("d_rerun_op", {op_rh_wl, op_addr, op_wr_data}, {1'b0, 5'd0, 16'h9140});
    wait_exec("d_w1", n);
    chk("d_w1_addr", 32'(op_addr), 4);
    wait_exec("d_w2", n);
    chk("d_w2_addr", 32'(op_addr), 9);
    wait_idle("d_w2", n);
    chk("d_cfg_done", 32'(cfg_done), 1);
    wait_exec("d_poll", n);
    chk("d_no_dup_gap", n, POLL_PERIOD);
    chk("d_no_dup_op", {op_rh_wl, op_addr}, {1'b1, 5'd1});
    wait_exec("d_pssr", n);
    wait_idle("d_pssr", n);

    // 6: reset mid CFG_WAIT
    pulse_restart();
    wait_exec("r_w0", n);
    repeat (10) tick();
    chk("r_pre", {busy, link_up}, 2'b11);
    sys_rst = 1'b1;
    #1;
    chk("r_outs", {busy, op_exec, cfg_done, cfg_err, link_up, link_speed, op_rh_wl}, 0);
    chk("r_addr_data", {op_addr, op_wr_data}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_exec("r_pwrup", n);
    chk("r_pwrup_lat", n, PWRUP_DLY);
    chk("r_w0_op", {op_addr, op_wr_data}, {5'd0, 16'h9140});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
